prog_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory through its write port before the core runs. It sits directly upstream of the instruction ROM. It consumes bytes from a UART receiver via a valid/ready handshake, parses a framed image (sync, length, payload, checksum), and assembles little-endian 32-bit words. It issues one ROM write per word and holds the CPU while a load is in progress.

---
 rtl/prog_loader_pkg.sv | 14 +
 rtl/prog_loader_byte_packer.sv | 29 ++
 rtl/prog_loader.sv | 122 ++++++++++++
 tb/tb_prog_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared FSM states and constants for the program loader and instruction ROM.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEN,
        DATA,
        CHK
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int ROM_DEPTH = 4096;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// prog_loader_byte_packer: collects four bytes little-endian and flags the byte completing a word.
module prog_loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        last
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    // The completing byte is folded in combinationally so the word is usable on its accepting edge.
    assign word = {data, sr};
    assign last = shift && cnt == 2'd3;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift) begin
            sr  <= {data, sr[23:8]};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: parses a framed byte stream (sync, length, payload, checksum) into ROM word writes.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] BASE_ADDR = '0,
    parameter int               MAX_WORDS = ROM_DEPTH,
    parameter logic [7:0]       SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             wr_en,
    output logic [WIDTH-1:0] wr_addr_o,
    output logic [WIDTH-1:0] wr_data_o,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int IW = $clog2(MAX_WORDS + 1);

    state_t           state, state_d;
    logic [IW-1:0]    n, n_d, idx, idx_d;
    logic [7:0]       sum, sum_d;
    logic             err_d, done_d, wr_en_d;
    logic [WIDTH-1:0] wr_addr_d, wr_data_d;
    logic             acc, shift, clr, last;
    logic [31:0]      word;

    // One write per four bytes can never back up, so the loader only refuses bytes while in reset.
    assign rx_ready = !rst;
    assign acc      = rx_valid && rx_ready;
    assign shift    = acc && (state == LEN || state == DATA);
    assign clr      = acc && state == IDLE && rx_data == SYNC_BYTE;
    assign busy     = state != IDLE;
    assign cpu_hold = busy;

    prog_loader_byte_packer u_packer (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .shift (shift),
        .data  (rx_data),
        .word  (word),
        .last  (last)
    );

    always_comb begin
        state_d   = state;
        n_d       = n;
        idx_d     = idx;
        sum_d     = sum;
        err_d     = err;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_o;
        wr_data_d = wr_data_o;
        if (acc) begin
            case (state)
                IDLE: if (rx_data == SYNC_BYTE) begin
                    state_d = LEN;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    sum_d   = '0;
                end
                LEN: if (last) begin
                    if (word > 32'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        n_d     = IW'(word);
                        state_d = word == 32'd0 ? CHK : DATA;
                    end
                end
                DATA: begin
                    sum_d = sum ^ rx_data;
                    if (last) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = BASE_ADDR + (WIDTH'(idx) << 2);
                        wr_data_d = WIDTH'(word);
                        idx_d     = idx + 1'b1;
                        state_d   = idx_d == n ? CHK : DATA;
                    end
                end
                default: begin
                    done_d  = rx_data == sum;
                    err_d   = rx_data != sum;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n         <= '0;
            idx       <= '0;
            sum       <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr_o <= BASE_ADDR;
            wr_data_o <= '0;
        end else begin
            state     <= state_d;
            n         <= n_d;
            idx       <= idx_d;
            sum       <= sum_d;
            err       <= err_d;
            done      <= done_d;
            wr_en     <= wr_en_d;
            wr_addr_o <= wr_addr_d;
            wr_data_o <= wr_data_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: frame-level reference model feeding an event scoreboard for the program loader.
`timescale 1ns/1ps
module tb_prog_loader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          MAXW = 4096;
    localparam int          EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready, wr_en, busy, cpu_hold, done, err;
    logic [31:0] wr_addr_o, wr_data_o;

    int   errors = 0;
    int   checks = 0;
    ev_t  exp_q[$];
    logic err_prev = 1'b0;

    prog_loader #(.WIDTH(32), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .wr_en     (wr_en),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o),
        .busy      (busy),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, required no event", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_WR && e.kind == EV_WR) begin
                chk("wr_addr", a, e.addr);
                chk("wr_data", d, e.data);
            end
        end
    endtask

    // Monitor: every DUT-visible event is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cpu_hold_eq_busy", cpu_hold, busy);
            if (wr_en) observe(EV_WR, wr_addr_o, wr_data_o);
            if (done) observe(EV_DONE, 0, 0);
            if (err && !err_prev) observe(EV_ERR, 0, 0);
        end
        err_prev = err;
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int lo, input int hi);
        idle($urandom_range(hi, lo));
    endtask

    // cs < 0 sends the correct checksum; otherwise the low byte of cs is sent as-is.
    task automatic send_frame(input logic [31:0] n, input logic [31:0] ws[$], input int cs,
                              input int glo, input int ghi);
        logic [7:0]  c, cb, b;
        logic [31:0] w;
        bit          big;
        big = n > MAXW;
        send(8'hA5);
        chk("busy_after_sync", busy, 1);
        chk("err_clr_on_sync", err, 0);
        gap(glo, ghi);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && big) push(EV_ERR, 0, 0);
            b = n[8*i +: 8];
            send(b);
            chk("busy_len", busy, (i == 3 && big) ? 0 : 1);
            gap(glo, ghi);
        end
        if (!big) begin
            c = 8'h00;
            for (int k = 0; k < int'(n); k++) begin
                w = ws[k];
                push(EV_WR, BASE + 32'(k) * 4, w);
                for (int j = 0; j < 4; j++) begin
                    b = w[8*j +: 8];
                    c = c ^ b;
                    send(b);
                    chk("busy_data", busy, 1);
                    gap(glo, ghi);
                end
            end
            cb = cs < 0 ? c : 8'(cs);
            push(cb == c ? EV_DONE : EV_ERR, 0, 0);
            send(cb);
            chk("busy_after_chk", busy, 0);
            gap(glo, ghi);
        end
    endtask

    task automatic garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b);
            chk("busy_garbage", busy, 0);
        end
    endtask

    initial begin
        logic [31:0] plan[$];
        logic [31:0] ws[$];
        logic [31:0] n;
        plan = '{32'h12345678, 32'hDEADBEEF};
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_addr", wr_addr_o, BASE);
        chk("rst_wr_data", wr_data_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rx_ready_after_rst", rx_ready, 1);
        idle(1);

        // Reference frame: payload XOR is 0x2A.
        send_frame(2, plan, -1, 0, 0);
        idle(3);
        chk("done_frame_err", err, 0);

        send_frame(2, plan, 8'h00, 0, 0);
        idle(5);
        chk("err_sticky", err, 1);

        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        chk("garbage_idle", busy, 0);
        send_frame(2, plan, -1, 3, 3);
        idle(3);
        chk("gapped_frame_err", err, 0);

        ws.delete();
        send_frame(32'h0000_1001, ws, -1, 0, 0);
        idle(3);
        chk("oversize_idle", busy, 0);
        send_frame(32'hFFFF_FFFF, ws, -1, 0, 1);
        send_frame(0, ws, 8'h00, 0, 0);
        idle(3);
        chk("zero_len_err", err, 0);

        // Reset after the sixth payload byte: only the first word was ever complete.
        push(EV_WR, BASE, plan[0]);
        send(8'hA5);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hold", cpu_hold, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        idle(4);
        chk("rst_mid_pending", exp_q.size(), 0);
        send_frame(2, plan, -1, 0, 0);

        ws.delete();
        for (int k = 0; k < MAXW; k++) ws.push_back($urandom);
        send_frame(MAXW, ws, -1, 0, 0);

        for (int f = 0; f < 40; f++) begin
            garbage($urandom_range(3, 0));
            n = $urandom_range(6, 0);
            if ($urandom_range(9, 0) == 0) n = 32'(MAXW + 1) + $urandom_range(100000, 0);
            ws.delete();
            for (int k = 0; k < 6; k++) ws.push_back($urandom);
            send_frame(n, ws, ($urandom_range(4, 0) == 0) ? int'($urandom_range(255, 0)) : -1, 0, 2);
        end

        idle(10);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_busy", busy, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
